// File: rtl/vec_lane_collector.sv
// Write-back collector: gathers per-lane element chunks into one VLEN-bit result and
// hands it to the vector register file over a valid/ready handshake.
//
// state     | meaning
// S_IDLE    | waiting for start; last result/mask/err retained
// S_COLLECT | merging chunks from active lanes into the result
// S_WB      | result presented, waiting for wb_ready
module vec_lane_collector #(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 5,
  parameter int MAX_LANES  = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [2:0]                vsew,
  input  logic [1:0]                nb_lanes,
  input  logic [4:0]                vd_addr,
  input  logic [MAX_LANES-1:0]      lane_valid,
  input  logic [MAX_LANES-1:0]      lane_done,
  input  logic [MAX_LANES*VLEN-1:0] lane_vd,
  input  logic [MAX_LANES*10-1:0]   lane_idx,
  output logic                      busy,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [VLEN-1:0]           wb_data,
  output logic [4:0]                wb_addr,
  output logic [VLEN/8-1:0]         wb_mask,
  output logic                      err
);

  localparam int NB = VLEN / 8;
  localparam int CNTW = $clog2(NB) + 2;
  localparam logic [2:0] MAXE = 3'(LANE_WIDTH - 3);
  localparam logic [11:0] VLEN_W = 12'(VLEN);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WB} state_t;

  state_t state_q, state_n;

  logic [2:0]      sew_q;
  logic [1:0]      nbl_q;
  logic [CNTW-1:0] cnt_q;

  logic [2:0]           ecode;
  logic [11:0]          cw;
  logic [CNTW-1:0]      n_exp;
  logic [4:0]           act_cnt;
  logic [MAX_LANES-1:0] act_mask;

  logic [VLEN-1:0] data_n;
  logic [NB-1:0]   mask_n;
  logic            err_n;
  logic [CNTW-1:0] add;
  logic [CNTW:0]   cnt_sum;
  logic [CNTW-1:0] cnt_next;
  logic            any_valid;
  logic            all_done;
  logic            early;
  logic [11:0]     idx;

  // Chunk width is the element width capped at the lane datapath width; both are powers of 2.
  assign ecode   = (sew_q > MAXE) ? MAXE : sew_q;
  assign cw      = 12'd8 << ecode;
  assign n_exp   = CNTW'(NB) >> ecode;
  assign act_cnt = 5'd1 << nbl_q;

  always_comb begin
    for (int i = 0; i < MAX_LANES; i++) act_mask[i] = (5'(i) < act_cnt);
  end

  // Lanes are merged in ascending order so the highest lane wins a same-cycle collision.
  always_comb begin
    data_n    = wb_data;
    mask_n    = wb_mask;
    err_n     = err;
    add       = '0;
    any_valid = 1'b0;
    all_done  = 1'b1;
    idx       = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (act_mask[i]) begin
        if (!lane_done[i]) all_done = 1'b0;
        if (lane_valid[i]) begin
          any_valid = 1'b1;
          idx = {2'b00, lane_idx[i*10 +: 10]};
          if ((idx + cw > VLEN_W) || ((idx & (cw - 12'd1)) != 12'd0)) begin
            err_n = 1'b1;
          end else begin
            add = add + CNTW'(1);
            for (int b = 0; b < VLEN; b++) begin
              if (12'(b) >= idx && 12'(b) < idx + cw) data_n[b] = lane_vd[i*VLEN + b];
            end
            for (int k = 0; k < NB; k++) begin
              if (12'(k*8) >= idx && 12'(k*8) < idx + cw) begin
                if (mask_n[k]) err_n = 1'b1;
                mask_n[k] = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  assign cnt_sum  = {1'b0, cnt_q} + {1'b0, add};
  assign cnt_next = cnt_sum[CNTW] ? '1 : cnt_sum[CNTW-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    early   = 1'b0;
    case (state_q)
      S_IDLE:    if (start) state_n = S_COLLECT;
      S_COLLECT: begin
        if (cnt_next >= n_exp) begin
          state_n = S_WB;
        end else if (all_done && !any_valid) begin
          state_n = S_WB;
          early   = 1'b1;
        end
      end
      S_WB:      if (wb_ready) state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sew_q   <= '0;
      nbl_q   <= '0;
      cnt_q   <= '0;
      wb_data <= '0;
      wb_mask <= '0;
      wb_addr <= '0;
      err     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sew_q   <= vsew;
            nbl_q   <= nb_lanes;
            wb_addr <= vd_addr;
            cnt_q   <= '0;
            wb_data <= '0;
            wb_mask <= '0;
            err     <= 1'b0;
          end
        end
        S_COLLECT: begin
          wb_data <= data_n;
          wb_mask <= mask_n;
          cnt_q   <= cnt_next;
          err     <= err_n | early;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign wb_valid = (state_q == S_WB);

endmodule

// File: tb/tb_vec_lane_collector.sv
// Self-checking bench for vec_lane_collector: directed scenarios plus randomized ops
// checked against a byte-level reference model of the collection rules.
module tb_vec_lane_collector;

  logic         clk = 1'b0;
  logic         resetn, start, wb_ready;
  logic [2:0]   vsew;
  logic [1:0]   nb_lanes;
  logic [4:0]   vd_addr;
  logic [3:0]   lv, ld;
  logic [511:0] lvd;
  logic [39:0]  lidx;
  logic         busy, wb_valid, err;
  logic [127:0] wb_data;
  logic [4:0]   wb_addr;
  logic [15:0]  wb_mask;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [7:0] m_data [16];
  bit         m_mask [16];
  int         m_cnt, m_cw, m_n, m_act;
  bit         m_err, m_done;
  logic [4:0] m_addr;

  vec_lane_collector #(.VLEN(128), .LANE_WIDTH(5), .MAX_LANES(4)) dut (
    .clk(clk), .resetn(resetn), .start(start), .vsew(vsew), .nb_lanes(nb_lanes),
    .vd_addr(vd_addr), .lane_valid(lv), .lane_done(ld), .lane_vd(lvd), .lane_idx(lidx),
    .busy(busy), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_addr(wb_addr), .wb_mask(wb_mask), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] exp_data();
    logic [127:0] d = '0;
    for (int b = 0; b < 16; b++) d[b*8 +: 8] = m_data[b];
    return d;
  endfunction

  function automatic logic [15:0] exp_mask();
    logic [15:0] m = '0;
    for (int b = 0; b < 16; b++) m[b] = m_mask[b];
    return m;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 16; b++) begin
      m_data[b] = 8'h00;
      m_mask[b] = 1'b0;
    end
    m_cnt = 0;
    m_err = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic randomize_vd();
    for (int w = 0; w < 16; w++) lvd[w*32 +: 32] = $urandom;
  endtask

  task automatic do_start(input int sew, input int nbl, input logic [4:0] addr);
    vsew = 3'(sew);
    nb_lanes = 2'(nbl);
    vd_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    m_addr = addr;
    m_cw = ((8 << sew) < 32) ? (8 << sew) : 32;
    m_n = 128 / m_cw;
    m_act = ((1 << nbl) < 4) ? (1 << nbl) : 4;
    chk("start_busy", 128'(busy), 128'(1));
  endtask

  // Apply the currently driven lane inputs to the model, clock once, check wb_valid.
  task automatic step();
    bit any_v = 1'b0;
    bit all_d = 1'b1;
    for (int i = 0; i < m_act; i++) begin
      if (!ld[i]) all_d = 1'b0;
      if (lv[i]) begin
        int idx = int'(lidx[i*10 +: 10]);
        any_v = 1'b1;
        if (idx + m_cw > 128 || (idx % m_cw) != 0) begin
          m_err = 1'b1;
        end else begin
          m_cnt++;
          for (int b = idx / 8; b < (idx + m_cw) / 8; b++) begin
            if (m_mask[b]) m_err = 1'b1;
            m_mask[b] = 1'b1;
            m_data[b] = lvd[i*128 + b*8 +: 8];
          end
        end
      end
    end
    if (m_cnt >= m_n) m_done = 1'b1;
    else if (all_d && !any_v) begin
      m_done = 1'b1;
      m_err = 1'b1;
    end
    tick();
    lv = '0;
    ld = '0;
    chk("wb_valid_step", 128'(wb_valid), 128'(m_done));
  endtask

  task automatic finish_wb(input int delay);
    logic [127:0] d = exp_data();
    chk("wb_data", wb_data, d);
    chk("wb_mask", 128'(wb_mask), 128'(exp_mask()));
    chk("wb_addr", 128'(wb_addr), 128'(m_addr));
    chk("wb_err", 128'(err), 128'(m_err));
    for (int c = 0; c < delay; c++) begin
      start = 1'b1;
      vd_addr = ~m_addr;
      tick();
      chk("hold_valid", 128'(wb_valid), 128'(1));
      chk("hold_data", wb_data, d);
      chk("hold_addr", 128'(wb_addr), 128'(m_addr));
    end
    start = 1'b0;
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("idle_valid", 128'(wb_valid), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("keep_data", wb_data, d);
    chk("keep_err", 128'(err), 128'(m_err));
  endtask

  task automatic random_op();
    int sew = $urandom_range(0, 3);
    int nbl = $urandom_range(0, 3);
    bit early = ($urandom_range(0, 3) == 0);
    bit faults = $urandom_range(0, 1);
    int q[$];
    int cyc = 0;
    do_start(sew, nbl, 5'($urandom));
    for (int k = 0; k < m_n; k++) q.push_back(k * m_cw);
    q.shuffle();
    while (!m_done && cyc < 300) begin
      randomize_vd();
      lidx = {$urandom, $urandom};
      lv = 4'($urandom);
      ld = 4'($urandom);
      for (int i = 0; i < m_act; i++) begin
        int r = $urandom_range(0, 9);
        ld[i] = 1'b0;
        lv[i] = 1'b0;
        if (r < 6 && q.size() > 0) begin
          lv[i] = 1'b1;
          lidx[i*10 +: 10] = 10'(q.pop_front());
        end else if (r == 6 && faults) begin
          lv[i] = 1'b1;
          if (m_cw > 8 && $urandom_range(0, 1) == 1)
            lidx[i*10 +: 10] = 10'($urandom_range(0, m_n - 1) * m_cw + 8);
          else
            lidx[i*10 +: 10] = 10'($urandom_range(128, 1023));
        end else if (r == 7 && faults) begin
          lv[i] = 1'b1;
          lidx[i*10 +: 10] = 10'($urandom_range(0, m_n - 1) * m_cw);
        end
      end
      if (early && m_cnt >= 1 && $urandom_range(0, 2) == 0) begin
        for (int i = 0; i < m_act; i++) begin
          lv[i] = 1'b0;
          ld[i] = 1'b1;
        end
      end
      step();
      cyc++;
    end
    chk("op_timeout", 128'(m_done), 128'(1));
    finish_wb($urandom_range(0, 3));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; wb_ready = 1'b0;
    vsew = '0; nb_lanes = '0; vd_addr = '0;
    lv = '0; ld = '0; lvd = '0; lidx = '0;
    tick();
    tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(wb_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_data", wb_data, 128'(0));
    chk("rst_mask", 128'(wb_mask), 128'(0));
    chk("rst_addr", 128'(wb_addr), 128'(0));
    resetn = 1'b1;
    tick();

    // four 32b chunks in one cycle
    do_start(2, 2, 5'h0A);
    randomize_vd();
    for (int i = 0; i < 4; i++) begin
      lv[i] = 1'b1;
      lidx[i*10 +: 10] = 10'(i * 32);
      lvd[i*128 + i*32 +: 32] = 32'h1111_1111 * 32'(i + 1);
    end
    step();
    chk("t1_data", wb_data, 128'h44444444_33333333_22222222_11111111);
    chk("t1_mask", 128'(wb_mask), 128'h0000_FFFF);
    finish_wb(0);

    // byte elements over four cycles
    do_start(0, 2, 5'h03);
    for (int c = 0; c < 4; c++) begin
      randomize_vd();
      for (int i = 0; i < 4; i++) begin
        lv[i] = 1'b1;
        lidx[i*10 +: 10] = 10'((c * 4 + i) * 8);
        lvd[i*128 + (c*4+i)*8 +: 8] = 8'(c * 4 + i);
      end
      step();
    end
    chk("t2_data", wb_data, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    chk("t2_err", 128'(err), 128'(0));
    finish_wb(0);

    // 64b elements capped to 32b chunks, two lanes, backpressure
    do_start(3, 1, 5'h11);
    for (int c = 0; c < 2; c++) begin
      randomize_vd();
      for (int i = 0; i < 2; i++) begin
        lv[i] = 1'b1;
        lidx[i*10 +: 10] = 10'((c * 2 + i) * 32);
      end
      step();
    end
    finish_wb(3);

    // duplicate index and out-of-range index
    do_start(2, 2, 5'h07);
    randomize_vd();
    lv = 4'b0011; lidx[9:0] = 10'd0; lidx[19:10] = 10'd32;
    step();
    randomize_vd();
    lv = 4'b0011; lidx[9:0] = 10'd128; lidx[19:10] = 10'd32;
    step();
    randomize_vd();
    lv = 4'b0011; lidx[9:0] = 10'd64; lidx[19:10] = 10'd96;
    step();
    chk("t4_err", 128'(err), 128'(1));
    finish_wb(1);

    // early finish after two chunks
    do_start(2, 2, 5'h1F);
    randomize_vd();
    lv = 4'b0011; lidx[9:0] = 10'd0; lidx[19:10] = 10'd32;
    step();
    ld = 4'b1111;
    step();
    chk("t5_mask", 128'(wb_mask), 128'h0000_00FF);
    chk("t5_err", 128'(err), 128'(1));
    finish_wb(0);

    // reset mid-collect
    do_start(2, 2, 5'h05);
    randomize_vd();
    lv = 4'b0001; lidx[9:0] = 10'd0;
    step();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    model_clear();
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_valid", 128'(wb_valid), 128'(0));
    chk("t6_data", wb_data, 128'(0));
    chk("t6_mask", 128'(wb_mask), 128'(0));

    for (int n = 0; n < 40; n++) random_op();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
